// File: rtl/ps2_key_decoder_if.sv
// Signal bundle between a PS/2 device and the Pong key decoder.
// The device side (master) drives the raw PS/2 lines. The decoder side (slave) returns key and byte status.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] key1_code;
    logic [7:0] key2_code;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  key1_code, key2_code, rx_byte, rx_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output key1_code, key2_code, rx_byte, rx_valid, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host deframer plus make/break tracking for the two Pong paddle key pairs.
// Player 1 uses W/S. Player 2 uses the extended Up/Down keys.
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    ps2_key_decoder_if.slave   bus
);
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_W    = 8'h1D;
    localparam logic [7:0] CODE_S    = 8'h1B;
    localparam logic [7:0] CODE_UP   = 8'h75;
    localparam logic [7:0] CODE_DOWN = 8'h72;

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {B_NORMAL, B_EXT, B_BRK, B_EXT_BRK} byte_state_t;

    logic             clk_s1, clk_s2, dat_s1, dat_s2;
    logic             clk_filt;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    frame_state_t     fstate;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             par_bit;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q, frame_err_q;

    byte_state_t      bstate, bstate_n;
    logic             w_p, s_p, up_p, dn_p;
    logic             w_n, s_n, up_n, dn_n;
    logic             last1, last2, last1_n, last2_n;  // last1: 1 = S, last2: 1 = Down
    logic [7:0]       key1_q, key2_q, key1_n, key2_n;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_dat;
            dat_s2 <= dat_s1;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    // The falling edge is flagged in the same cycle the filter commits to 0, alongside the synchronized data.
    assign fall = clk_filt && !clk_s2 && (flt_cnt == FLT_W'(FILTER_LEN - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fstate      <= F_IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                unique case (fstate)
                    F_IDLE: begin
                        if (!dat_s2) begin
                            fstate  <= F_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    F_DATA: begin
                        shift_q <= {dat_s2, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) fstate <= F_PARITY;
                    end
                    F_PARITY: begin
                        par_bit <= dat_s2;
                        fstate  <= F_STOP;
                    end
                    F_STOP: begin
                        if (dat_s2 && (^{shift_q, par_bit})) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        fstate <= F_IDLE;
                    end
                    default: fstate <= F_IDLE;
                endcase
            end else if (fstate != F_IDLE) begin
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    fstate <= F_IDLE;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bstate_n = bstate;
        w_n      = w_p;
        s_n      = s_p;
        up_n     = up_p;
        dn_n     = dn_p;
        last1_n  = last1;
        last2_n  = last2;
        if (rx_valid_q) begin
            unique case (bstate)
                B_NORMAL: begin
                    if (rx_byte_q == CODE_EXT) bstate_n = B_EXT;
                    else if (rx_byte_q == CODE_BRK) bstate_n = B_BRK;
                    else if (rx_byte_q == CODE_W) begin
                        if (!w_p) last1_n = 1'b0;
                        w_n = 1'b1;
                    end else if (rx_byte_q == CODE_S) begin
                        if (!s_p) last1_n = 1'b1;
                        s_n = 1'b1;
                    end
                end
                B_EXT: begin
                    bstate_n = B_NORMAL;
                    if (rx_byte_q == CODE_BRK) bstate_n = B_EXT_BRK;
                    else if (rx_byte_q == CODE_UP) begin
                        if (!up_p) last2_n = 1'b0;
                        up_n = 1'b1;
                    end else if (rx_byte_q == CODE_DOWN) begin
                        if (!dn_p) last2_n = 1'b1;
                        dn_n = 1'b1;
                    end
                end
                B_BRK: begin
                    bstate_n = B_NORMAL;
                    if (rx_byte_q == CODE_W) w_n = 1'b0;
                    else if (rx_byte_q == CODE_S) s_n = 1'b0;
                end
                B_EXT_BRK: begin
                    bstate_n = B_NORMAL;
                    if (rx_byte_q == CODE_UP) up_n = 1'b0;
                    else if (rx_byte_q == CODE_DOWN) dn_n = 1'b0;
                end
                default: bstate_n = B_NORMAL;
            endcase
        end

        if (w_n && s_n)  key1_n = last1_n ? CODE_S : CODE_W;
        else if (w_n)    key1_n = CODE_W;
        else if (s_n)    key1_n = CODE_S;
        else             key1_n = 8'h00;

        if (up_n && dn_n) key2_n = last2_n ? CODE_DOWN : CODE_UP;
        else if (up_n)    key2_n = CODE_UP;
        else if (dn_n)    key2_n = CODE_DOWN;
        else              key2_n = 8'h00;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bstate <= B_NORMAL;
            w_p    <= 1'b0;
            s_p    <= 1'b0;
            up_p   <= 1'b0;
            dn_p   <= 1'b0;
            last1  <= 1'b0;
            last2  <= 1'b0;
            key1_q <= '0;
            key2_q <= '0;
        end else begin
            bstate <= bstate_n;
            w_p    <= w_n;
            s_p    <= s_n;
            up_p   <= up_n;
            dn_p   <= dn_n;
            last1  <= last1_n;
            last2  <= last2_n;
            key1_q <= key1_n;
            key2_q <= key2_n;
        end
    end

    assign bus.key1_code = key1_q;
    assign bus.key2_code = key2_q;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of byte frames with expected key codes.
// Hand sequences cover errors, timeout, glitches and reset.
module tb_ps2_key_decoder;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 30;
    localparam int GAP         = 40;

    typedef struct {
        logic [7:0] b;
        logic [7:0] k1;
        logic [7:0] k2;
    } vec_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    logic rv_d = 1'b0;
    logic [7:0] snap1 = 8'h00;
    logic [7:0] snap2 = 8'h00;

    // Counts pulses and captures the key codes one cycle after each rx_valid.
    always @(negedge sys_clk) begin
        if (rv_d) begin
            snap1 = bus.key1_code;
            snap2 = bus.key2_code;
        end
        rv_d = bus.rx_valid;
        if (bus.rx_valid)  rv_cnt++;
        if (bus.frame_err) fe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        rv_cnt = 0;
        fe_cnt = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0,
                              input logic bad_stop = 1'b0, input int nbits = 11);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_dat = bits[i];
            repeat (HALF) @(negedge sys_clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge sys_clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
        repeat (GAP) @(negedge sys_clk);
    endtask

    task automatic glitch(input int len);
        @(negedge sys_clk);
        bus.ps2_clk = 1'b0;
        repeat (len) @(negedge sys_clk);
        bus.ps2_clk = 1'b1;
        repeat (GAP) @(negedge sys_clk);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'h1D, 8'h1D, 8'h00});
        vecs.push_back('{8'hF0, 8'h1D, 8'h00});
        vecs.push_back('{8'h1D, 8'h00, 8'h00});
        vecs.push_back('{8'hE0, 8'h00, 8'h00});
        vecs.push_back('{8'h75, 8'h00, 8'h75});
        vecs.push_back('{8'hE0, 8'h00, 8'h75});
        vecs.push_back('{8'hF0, 8'h00, 8'h75});
        vecs.push_back('{8'h75, 8'h00, 8'h00});
        vecs.push_back('{8'h75, 8'h00, 8'h00});
        vecs.push_back('{8'h1D, 8'h1D, 8'h00});
        vecs.push_back('{8'h1B, 8'h1B, 8'h00});
        vecs.push_back('{8'h33, 8'h1B, 8'h00});
        vecs.push_back('{8'hF0, 8'h1B, 8'h00});
        vecs.push_back('{8'h1B, 8'h1D, 8'h00});
        vecs.push_back('{8'hF0, 8'h1D, 8'h00});
        vecs.push_back('{8'h1D, 8'h00, 8'h00});
        vecs.push_back('{8'hE0, 8'h00, 8'h00});
        vecs.push_back('{8'h72, 8'h00, 8'h72});
        vecs.push_back('{8'hE0, 8'h00, 8'h72});
        vecs.push_back('{8'h75, 8'h00, 8'h75});
        vecs.push_back('{8'hE0, 8'h00, 8'h75});
        vecs.push_back('{8'hF0, 8'h00, 8'h75});
        vecs.push_back('{8'h75, 8'h00, 8'h72});
        vecs.push_back('{8'hE0, 8'h00, 8'h72});
        vecs.push_back('{8'hF0, 8'h00, 8'h72});
        vecs.push_back('{8'h72, 8'h00, 8'h00});

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("reset key1_code", bus.key1_code, 8'h00);
        check("reset key2_code", bus.key2_code, 8'h00);
        check("reset rx_byte", bus.rx_byte, 8'h00);
        check("reset rx_valid", bus.rx_valid, 1'b0);
        check("reset frame_err", bus.frame_err, 1'b0);
        sys_rst_n = 1'b1;
        repeat (GAP) @(negedge sys_clk);

        foreach (vecs[i]) begin
            clear_counts();
            send_frame(vecs[i].b);
            check($sformatf("vec%0d rx_valid count", i), rv_cnt, 1);
            check($sformatf("vec%0d frame_err count", i), fe_cnt, 0);
            check($sformatf("vec%0d rx_byte", i), bus.rx_byte, vecs[i].b);
            check($sformatf("vec%0d key1 next cycle", i), snap1, vecs[i].k1);
            check($sformatf("vec%0d key2 next cycle", i), snap2, vecs[i].k2);
            check($sformatf("vec%0d key1_code", i), bus.key1_code, vecs[i].k1);
            check($sformatf("vec%0d key2_code", i), bus.key2_code, vecs[i].k2);
        end

        // Wrong parity: rejected without touching rx_byte or keys.
        clear_counts();
        send_frame(8'h1D, 1'b1);
        check("parity err frame_err", fe_cnt, 1);
        check("parity err rx_valid", rv_cnt, 0);
        check("parity err rx_byte", bus.rx_byte, 8'h72);
        check("parity err key1_code", bus.key1_code, 8'h00);
        clear_counts();
        send_frame(8'h1B);
        check("after parity err rx_valid", rv_cnt, 1);
        check("after parity err key1_code", bus.key1_code, 8'h1B);

        // Bad stop bit: rejected.
        clear_counts();
        send_frame(8'hF0, 1'b0, 1'b1);
        check("stop err frame_err", fe_cnt, 1);
        check("stop err rx_valid", rv_cnt, 0);
        check("stop err key1_code", bus.key1_code, 8'h1B);
        send_frame(8'hF0);
        send_frame(8'h1B);
        check("release S key1_code", bus.key1_code, 8'h00);

        // Partial frame abandoned by timeout, then a clean frame.
        clear_counts();
        send_frame(8'h1D, 1'b0, 1'b0, 5);
        repeat (TIMEOUT_CYC + 10) @(negedge sys_clk);
        send_frame(8'h1D);
        check("timeout rx_valid count", rv_cnt, 1);
        check("timeout frame_err count", fe_cnt, 0);
        check("timeout rx_byte", bus.rx_byte, 8'h1D);
        check("timeout key1_code", bus.key1_code, 8'h1D);
        send_frame(8'hF0);
        send_frame(8'h1D);
        check("release W key1_code", bus.key1_code, 8'h00);

        // Short glitch is filtered out. A 20-cycle one is a real idle edge with data high.
        clear_counts();
        glitch(4);
        check("short glitch frame_err", fe_cnt, 0);
        check("short glitch rx_valid", rv_cnt, 0);
        clear_counts();
        glitch(20);
        check("long glitch rx_valid", rv_cnt, 0);
        check("long glitch frame_err", fe_cnt, 1);
        clear_counts();
        send_frame(8'h1B);
        check("post glitch rx_byte", bus.rx_byte, 8'h1B);
        check("post glitch rx_valid", rv_cnt, 1);
        send_frame(8'hF0);
        send_frame(8'h1B);

        // Reset mid-frame while Up is held.
        send_frame(8'hE0);
        send_frame(8'h75);
        check("pre reset key2_code", bus.key2_code, 8'h75);
        send_frame(8'h1D, 1'b0, 1'b0, 4);
        #3 sys_rst_n = 1'b0;
        #1;
        check("mid reset key2_code", bus.key2_code, 8'h00);
        check("mid reset key1_code", bus.key1_code, 8'h00);
        check("mid reset rx_byte", bus.rx_byte, 8'h00);
        check("mid reset rx_valid", bus.rx_valid, 1'b0);
        check("mid reset frame_err", bus.frame_err, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (GAP) @(negedge sys_clk);
        clear_counts();
        send_frame(8'hE0);
        send_frame(8'h72);
        check("post reset rx_valid count", rv_cnt, 2);
        check("post reset frame_err count", fe_cnt, 0);
        check("post reset key2_code", bus.key2_code, 8'h72);
        check("post reset key1_code", bus.key1_code, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
